evm_ballot_unit: RTL and testbench

//   Voter-side ballot unit that drives the vote counter's voter_switch / Push_Button interface.

---
 rtl/evm_pkg.sv | 24 ++
 rtl/evm_ballot_unit_if.sv | 26 ++
 rtl/evm_key_debounce.sv | 37 +++
 rtl/evm_ballot_unit.sv | 107 ++++++++++
 tb/tb_evm_ballot_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/evm_pkg.sv
// evm_pkg: ballot states, one-hot party codes and active-low seven-segment digits
//   NUM_PARTY is fixed at 4 party keys / one-hot width in this revision.
package evm_pkg;
    localparam int NUM_PARTY = 4;
    typedef enum logic [2:0] {IDLE, ARMED, SETUP, STROBE, RELEASE} ballot_state_t;
    localparam logic [NUM_PARTY-1:0] PARTY1 = 4'b0001;
    localparam logic [NUM_PARTY-1:0] PARTY2 = 4'b0010;
    localparam logic [NUM_PARTY-1:0] PARTY3 = 4'b0100;
    localparam logic [NUM_PARTY-1:0] PARTY4 = 4'b1000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    function automatic logic one_hot(input logic [NUM_PARTY-1:0] k);
        return (k != '0) && ((k & (k - 1'b1)) == '0);
    endfunction
    function automatic logic [6:0] party_digit(input logic [NUM_PARTY-1:0] code);
        return code == PARTY1 ? SEG_DIGIT[1] :
               code == PARTY2 ? SEG_DIGIT[2] :
               code == PARTY3 ? SEG_DIGIT[3] :
               code == PARTY4 ? SEG_DIGIT[4] : SEG_BLANK;
    endfunction
endpackage

// File: rtl/evm_ballot_unit_if.sv
// evm_ballot_unit_if: keypad/control inputs and counter-side outputs of the ballot unit
//   master: the ballot unit (drives voter_switch/push_button and status lamps)
//   slave : the surrounding control unit, keypad and counter
interface evm_ballot_unit_if;
    import evm_pkg::*;
    logic                 ballot_issue;
    logic [NUM_PARTY-1:0] party_key;
    logic [NUM_PARTY-1:0] voter_switch;
    logic                 push_button;
    logic                 ballot_ready;
    logic                 busy;
    logic                 invalid_press;
    logic                 vote_done;
    logic                 ballot_expired;
    logic [6:0]           party_seg;
    modport master (
        input  ballot_issue, party_key,
        output voter_switch, push_button, ballot_ready, busy,
               invalid_press, vote_done, ballot_expired, party_seg
    );
    modport slave (
        output ballot_issue, party_key,
        input  voter_switch, push_button, ballot_ready, busy,
               invalid_press, vote_done, ballot_expired, party_seg
    );
endinterface

// File: rtl/evm_key_debounce.sv
// evm_key_debounce: two-flop synchronizer plus stable-sample counter for one key
//   clk, reset (async, active-high); key_raw asynchronous input; key_db debounced level
module evm_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_db
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic          s1_q, s2_q, db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // counter only advances while the synchronized level disagrees with the accepted one
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = s2_q;
            else cnt_d = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= key_raw;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end
    assign key_db = db_q;
endmodule

// File: rtl/evm_ballot_unit.sv
// evm_ballot_unit: one-vote-per-ballot keypad front end for the vote counter
//   clk, reset (async, active-high); bus (master): ballot_issue/party_key in,
//   voter_switch/push_button to counter, ballot_ready/busy/invalid_press lamps,
//   vote_done/ballot_expired pulses, party_seg active-low confirmation digit
module evm_ballot_unit
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETUP_CYCLES    = 2,
    parameter int STROBE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input logic               clk,
    input logic               reset,
    evm_ballot_unit_if.master bus
);
    localparam int MAX_SS     = SETUP_CYCLES > STROBE_CYCLES ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_CYCLES = TIMEOUT_CYCLES > MAX_SS ? TIMEOUT_CYCLES : MAX_SS;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    ballot_state_t        state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [NUM_PARTY-1:0] key_db, vs_q, vs_d;
    logic                 push_q, push_d, done_q, done_d, exp_q, exp_d;
    for (genvar i = 0; i < NUM_PARTY; i++) begin : g_key
        evm_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .reset   (reset),
            .key_raw (bus.party_key[i]),
            .key_db  (key_db[i])
        );
    end
    // one counter serves the timeout, setup and strobe phases; it saturates rather than wraps
    assign cnt_inc = cnt_q == CW'(MAX_CYCLES) ? cnt_q : cnt_q + 1'b1;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vs_d    = vs_q;
        done_d  = 1'b0;
        exp_d   = 1'b0;
        unique case (state_q)
            IDLE: if (bus.ballot_issue) begin
                state_d = ARMED;
                cnt_d   = '0;
            end
            ARMED: begin
                cnt_d = cnt_inc;
                // a valid key wins over a timeout landing in the same cycle
                if (one_hot(key_db)) begin
                    state_d = SETUP;
                    vs_d    = key_db;
                    cnt_d   = '0;
                end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                    exp_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CW'(SETUP_CYCLES)) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                end
            end
            STROBE: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CW'(STROBE_CYCLES)) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: if (key_db == '0) begin
                state_d = IDLE;
                vs_d    = '0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // strobe is registered from the next state so it rises and falls on clean edges
    assign push_d = state_d == STROBE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vs_q    <= '0;
            push_q  <= 1'b0;
            done_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vs_q    <= vs_d;
            push_q  <= push_d;
            done_q  <= done_d;
            exp_q   <= exp_d;
        end
    end
    assign bus.voter_switch   = vs_q;
    assign bus.push_button    = push_q;
    assign bus.ballot_ready   = state_q == ARMED;
    assign bus.busy           = state_q != IDLE;
    assign bus.invalid_press  = state_q == ARMED && key_db != '0 && !one_hot(key_db);
    assign bus.vote_done      = done_q;
    assign bus.ballot_expired = exp_q;
    assign bus.party_seg      = party_digit(vs_q);
endmodule

// File: tb/tb_evm_ballot_unit.sv
module tb_evm_ballot_unit;
    localparam logic [6:0]  B  = 7'b1111111;
    localparam logic [6:0]  D1 = 7'b1001111;
    localparam logic [6:0]  D2 = 7'b0010010;
    localparam logic [6:0]  D3 = 7'b0000110;
    localparam logic [6:0]  D4 = 7'b1001100;
    localparam logic [16:0] IDLE_OUTS = 17'h0007f;
    localparam logic [16:0] DONE_OUTS = 17'h0017f;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    evm_ballot_unit_if bus ();
    evm_ballot_unit dut (.clk(clk), .reset(reset), .bus(bus));
    int checks = 0;
    int failures = 0;
    logic [16:0] outs;
    assign outs = {bus.voter_switch, bus.push_button, bus.ballot_ready, bus.busy,
                   bus.invalid_press, bus.vote_done, bus.ballot_expired, bus.party_seg};
    typedef struct {
        string       name;
        logic        issue;
        logic [3:0]  key;
        int          n;
        logic [16:0] exp;
    } step_t;
    step_t tbl [21];

    function automatic step_t mk(input string nm, input logic iss, input logic [3:0] key, input int n,
                                 input logic [3:0] vs, input logic push, input logic rdy, input logic bsy,
                                 input logic inv, input logic dn, input logic ex, input logic [6:0] seg);
        step_t s;
        s.name  = nm;
        s.issue = iss;
        s.key   = key;
        s.n     = n;
        s.exp   = {vs, push, rdy, bsy, inv, dn, ex, seg};
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic wait_push(input int bound, output int k);
        k = 0;
        while (!bus.push_button && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (bus.push_button && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(input int bound, output int k, output int rises);
        logic prev;
        prev = bus.push_button;
        k = 0;
        rises = 0;
        while (!bus.vote_done && k < bound) begin
            @(negedge clk);
            k++;
            if (bus.push_button && !prev) rises++;
            prev = bus.push_button;
        end
    endtask

    task automatic normal_vote(input logic [3:0] key, input logic [6:0] seg, input string nm);
        int k, n, r;
        bus.ballot_issue = 1'b1;
        bus.party_key = key;
        @(negedge clk);
        bus.ballot_issue = 1'b0;
        wait_push(100, k);
        chk({nm, "_latency"}, k + 1, 21);
        chk({nm, "_vs"}, bus.voter_switch, key);
        chk({nm, "_seg"}, bus.party_seg, seg);
        count_high(n);
        chk({nm, "_strobe_len"}, n, 4);
        bus.party_key = 4'b0000;
        wait_done(100, k, r);
        chk({nm, "_done_seen"}, k < 100, 1);
        chk({nm, "_extra_strobe"}, r, 0);
        chk({nm, "_done_outs"}, outs, DONE_OUTS);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, r, bad;
        logic prev;
        tbl[0]  = mk("s1_armed",        1, 4'b0010,  1, 4'b0000, 0, 1, 1, 0, 0, 0, B);
        tbl[1]  = mk("s1_pre_accept",   0, 4'b0010, 17, 4'b0000, 0, 1, 1, 0, 0, 0, B);
        tbl[2]  = mk("s1_accept",       0, 4'b0010,  1, 4'b0010, 0, 0, 1, 0, 0, 0, D2);
        tbl[3]  = mk("s1_setup2",       0, 4'b0010,  1, 4'b0010, 0, 0, 1, 0, 0, 0, D2);
        tbl[4]  = mk("s1_strobe_rise",  0, 4'b0010,  1, 4'b0010, 1, 0, 1, 0, 0, 0, D2);
        tbl[5]  = mk("s1_strobe_last",  0, 4'b0010,  3, 4'b0010, 1, 0, 1, 0, 0, 0, D2);
        tbl[6]  = mk("s1_strobe_fall",  0, 4'b0010,  1, 4'b0010, 0, 0, 1, 0, 0, 0, D2);
        tbl[7]  = mk("s1_release_hold", 0, 4'b0010, 15, 4'b0010, 0, 0, 1, 0, 0, 0, D2);
        tbl[8]  = mk("s1_release_wait", 0, 4'b0000, 18, 4'b0010, 0, 0, 1, 0, 0, 0, D2);
        tbl[9]  = mk("s1_vote_done",    0, 4'b0000,  1, 4'b0000, 0, 0, 0, 0, 1, 0, B);
        tbl[10] = mk("s1_done_cleared", 0, 4'b0000,  1, 4'b0000, 0, 0, 0, 0, 0, 0, B);
        tbl[11] = mk("s2_armed",        1, 4'b0101,  1, 4'b0000, 0, 1, 1, 0, 0, 0, B);
        tbl[12] = mk("s2_pre_invalid",  0, 4'b0101, 16, 4'b0000, 0, 1, 1, 0, 0, 0, B);
        tbl[13] = mk("s2_invalid",      0, 4'b0101,  1, 4'b0000, 0, 1, 1, 1, 0, 0, B);
        tbl[14] = mk("s2_invalid_hold", 0, 4'b0101, 12, 4'b0000, 0, 1, 1, 1, 0, 0, B);
        tbl[15] = mk("s2_one_left",     0, 4'b0001, 18, 4'b0000, 0, 1, 1, 0, 0, 0, B);
        tbl[16] = mk("s2_accept",       0, 4'b0001,  1, 4'b0001, 0, 0, 1, 0, 0, 0, D1);
        tbl[17] = mk("s2_strobe",       0, 4'b0001,  2, 4'b0001, 1, 0, 1, 0, 0, 0, D1);
        tbl[18] = mk("s2_strobe_fall",  0, 4'b0000,  4, 4'b0001, 0, 0, 1, 0, 0, 0, D1);
        tbl[19] = mk("s2_release_wait", 0, 4'b0000, 14, 4'b0001, 0, 0, 1, 0, 0, 0, D1);
        tbl[20] = mk("s2_vote_done",    0, 4'b0000,  1, 4'b0000, 0, 0, 0, 0, 1, 0, B);

        bus.ballot_issue = 1'b0;
        bus.party_key = 4'b0000;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs, IDLE_OUTS);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", outs, IDLE_OUTS);

        for (int i = 0; i < 21; i++) begin
            bus.ballot_issue = tbl[i].issue;
            bus.party_key = tbl[i].key;
            @(negedge clk);
            bus.ballot_issue = 1'b0;
            repeat (tbl[i].n - 1) @(negedge clk);
            chk(tbl[i].name, outs, tbl[i].exp);
        end

        bus.ballot_issue = 1'b1;
        @(negedge clk);
        bus.ballot_issue = 1'b0;
        chk("s3_armed_ready", bus.ballot_ready, 1);
        k = 1;
        r = 0;
        while (!bus.ballot_expired && k < 1100) begin
            @(negedge clk);
            k++;
            if (bus.push_button) r++;
        end
        chk("s3_expire_cycle", k - 1, 1024);
        chk("s3_expire_outs", outs, 17'h0007f | 17'h00080);
        chk("s3_no_strobe", r, 0);
        @(negedge clk);
        chk("s3_expire_pulse_end", outs, IDLE_OUTS);

        bus.ballot_issue = 1'b1;
        bad = 0;
        for (int ph = 0; ph < 12; ph++) begin
            bus.party_key = (ph % 2 == 0) ? 4'b0001 : 4'b0000;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                bus.ballot_issue = 1'b0;
                if (bus.voter_switch != 4'b0000 || bus.push_button) bad++;
            end
        end
        chk("s4_no_accept_bouncing", bad, 0);
        chk("s4_still_armed", bus.ballot_ready, 1);
        bus.party_key = 4'b0001;
        wait_push(100, k);
        chk("s4_latency", k, 21);
        count_high(n);
        chk("s4_strobe_len", n, 4);
        bus.party_key = 4'b0000;
        wait_done(100, k, r);
        chk("s4_done_seen", k < 100, 1);
        chk("s4_single_strobe", r, 0);

        bus.ballot_issue = 1'b1;
        bus.party_key = 4'b1000;
        @(negedge clk);
        bus.ballot_issue = 1'b0;
        repeat (4) @(negedge clk);
        bus.ballot_issue = 1'b1;
        @(negedge clk);
        bus.ballot_issue = 1'b0;
        wait_push(100, k);
        chk("s5_latency", k + 6, 21);
        count_high(n);
        chk("s5_strobe_len", n, 4);
        r = 0;
        prev = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c == 30) bus.ballot_issue = 1'b1;
            @(negedge clk);
            bus.ballot_issue = 1'b0;
            if (bus.push_button && !prev) r++;
            prev = bus.push_button;
        end
        chk("s5_no_second_strobe", r, 0);
        chk("s5_release_hold", outs, {4'b1000, 6'b001000, D4});
        bus.party_key = 4'b0000;
        wait_done(100, k, r);
        chk("s5_done_seen", k < 100, 1);
        chk("s5_no_strobe_in_release", r, 0);
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.busy || bus.ballot_ready) bad++;
        end
        chk("s5_issue_not_queued", bad, 0);
        bus.party_key = 4'b1000;
        repeat (30) @(negedge clk);
        chk("s5_held_key_idle", outs, IDLE_OUTS);
        bus.ballot_issue = 1'b1;
        @(negedge clk);
        bus.ballot_issue = 1'b0;
        chk("s5_held_armed", bus.ballot_ready, 1);
        wait_push(100, k);
        chk("s5_held_latency", k + 1, 4);
        chk("s5_held_vs_seg", {bus.voter_switch, bus.party_seg}, {4'b1000, D4});
        count_high(n);
        chk("s5_held_strobe_len", n, 4);
        bus.party_key = 4'b0000;
        wait_done(100, k, r);
        chk("s5_held_done_seen", k < 100, 1);

        bus.ballot_issue = 1'b1;
        bus.party_key = 4'b0100;
        @(negedge clk);
        bus.ballot_issue = 1'b0;
        wait_push(100, k);
        chk("s6_latency", k + 1, 21);
        @(negedge clk);
        chk("s6_second_strobe_cycle", bus.push_button, 1);
        #2 reset = 1'b1;
        #1;
        chk("s6_reset_push_now", bus.push_button, 0);
        chk("s6_reset_outs", outs, IDLE_OUTS);
        bus.party_key = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("s6_idle_after_reset", outs, IDLE_OUTS);
        normal_vote(4'b0100, D3, "s6_next");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
